pc_fetch_sequencer: RTL and testbench
=====================================

# pc_fetch_sequencer

Program-counter and fetch sequencer that produces the current instruction address and its sequential successor for the IF/ID pipeline register. Each cycle it either advances sequentially, holds under a pipeline stall, or redirects to a branch/jump target. On a redirect it marks the wrong-path slot for flushing and issues a one-cycle bubble. Sits between hazard/branch resolution logic and the IF/ID address register.

## Interface
- ADDR_W, 8, address width; all address arithmetic is modulo 2^ADDR_W
- RESET_PC, 8'h00, address fetched first after reset
- PC_INC, 1, sequential increment (word-addressed instruction memory)
- CNT_W, 16, width of the issued-instruction counter
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset values immediately
- stall  in  1  hold PC this cycle (hazard unit)
- redirect  in  1  branch taken or jump; target valid this cycle
- redirect_target  in  ADDR_W  new PC when redirect=1
- Current_Address  out  ADDR_W  registered PC of the instruction being fetched
- IA  out  ADDR_W  registered Current_Address + PC_INC
- fetch_valid  out  1  Current_Address is a real (non-bubble) fetch
- flush  out  1  one-cycle pulse: IF/ID contents are wrong-path and must be zeroed
- stalled  out  1  state is HOLD
- instr_count  out  CNT_W  saturating count of sequentially retired fetches

## Operation
- States: IDLE, FETCH, HOLD, REDIR (encoding 2'b00, 2'b01, 2'b10, 2'b11).
- Reset values: state=IDLE, Current_Address=RESET_PC, IA=RESET_PC+PC_INC, fetch_valid=0, flush=0, stalled=0, instr_count=0.
- IDLE: next edge -> FETCH unconditionally; PC unchanged; stall and redirect ignored.
- FETCH: fetch_valid=1.
  - redirect=1 -> PC<=redirect_target, go to REDIR.
  - else stall=1 -> PC held, go to HOLD.
  - else -> PC<=IA, stay in FETCH, instr_count++.
- HOLD: fetch_valid=1, stalled=1.
  - redirect=1 -> PC<=redirect_target, go to REDIR.
  - else stall=0 -> PC<=IA, go to FETCH, instr_count++.
  - else stay in HOLD.
- REDIR: fetch_valid=0, flush=1. PC held at target. Next edge -> FETCH unconditionally; stall and redirect ignored for this one cycle.
- Priority: reset > redirect > stall > advance.
- IA is always recomputed with the PC: IA = (PC + PC_INC) mod 2^ADDR_W. PC=8'hFF gives IA=8'h00.
- instr_count saturates at all-ones and never wraps. The fetch on a redirect edge is wrong-path and is not counted.
- All outputs are registered; no combinational input-to-output path.

## Timing
- After reset deassertion: edge 1 -> FETCH with Current_Address=RESET_PC and fetch_valid=1.
- Sequential throughput: one address per cycle.
- Stall: asserted in cycle n -> Current_Address identical in cycle n+1. Advance occurs on the first edge that samples stall=0.
- Redirect sampled at edge k:
  - cycle k+1: Current_Address=target, flush=1, fetch_valid=0.
  - cycle k+2: fetch_valid=1 at target.
  - Redirect-to-valid-target latency: 2 cycles.
- Reset asserted mid-operation (any state): outputs return to reset values asynchronously. No pending redirect or stall survives.

## Structure
- Shared package holds: state typedef and encodings, ADDR_W default, RESET_PC default.
- One natural sub-module: sat_counter (CNT_W-wide, enable input, saturating, async active-low reset) for instr_count.
- Next-PC mux, IA adder and FSM stay in the top module.

## Test plan
- Reset release, stall=0, redirect=0 for 4 cycles -> Current_Address 00,00,01,02,03; IA 01,01,02,03,04; fetch_valid 0,1,1,1,1; instr_count reaches 3.
- Stall held 3 cycles while PC=05 -> Current_Address stays 05 and stalled=1 for those cycles. First edge with stall=0 -> PC=06 and stalled=0.
- redirect=1 with target=8'h40 and stall=1 in the same cycle at PC=10 -> next cycle Current_Address=40, IA=41, flush=1, fetch_valid=0. Following cycle fetch_valid=1. instr_count unchanged by the redirect edge.
- Sequential run through PC=FE -> Current_Address FE, FF, 00; IA at FF equals 00.
- Reset pulsed low mid-cycle while in REDIR -> outputs drop to reset values before the next clk edge. Post-reset sequence matches the first test.
- instr_count preloaded near saturation (CNT_W=4 build) with 20 sequential advances -> holds at 4'hF.

Source files
------------

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the program-counter / fetch sequencer:
// state encoding and default address parameters.
package pc_fetch_sequencer_pkg;

  localparam int         ADDR_W_DEF   = 8;
  localparam logic [7:0] RESET_PC_DEF = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10,
    ST_REDIR = 2'b11
  } fetch_state_e;

  // A state whose fetch slot carries a real (non-bubble) instruction.
  function automatic logic is_fetching(input fetch_state_e s);
    return (s == ST_FETCH) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_sat_counter.sv
// Saturating up-counter: increments when en is high, sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Count enabled events, holding once every bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (en && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter and fetch sequencer feeding the IF/ID address register.
// Advances, holds under stall, or redirects (with a one-cycle flushed bubble).
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int                PC_INC   = 1,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] Current_Address,
  output logic [ADDR_W-1:0] IA,
  output logic              fetch_valid,
  output logic              flush,
  output logic              stalled,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  fetch_state_e      state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s, ia_r;
  logic              fetch_valid_r, flush_r, stalled_r;
  logic              cnt_en_s;

  // Next state, next PC and retire-count enable; redirect beats stall beats advance.
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    cnt_en_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_s = ST_FETCH;
      end
      ST_FETCH, ST_HOLD: begin
        if (redirect) begin
          pc_s    = redirect_target;
          state_s = ST_REDIR;
        end else if (stall) begin
          state_s = ST_HOLD;
        end else begin
          pc_s     = pc_r + INC;
          state_s  = ST_FETCH;
          cnt_en_s = 1'b1;
        end
      end
      ST_REDIR: begin
        state_s = ST_FETCH;
      end
      default: begin
        state_s = ST_IDLE;
        pc_s    = RESET_PC;
      end
    endcase
  end

  // State, PC, successor address and status flags, all registered from next-state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_PC;
      ia_r          <= RESET_PC + INC;
      fetch_valid_r <= 1'b0;
      flush_r       <= 1'b0;
      stalled_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      ia_r          <= pc_s + INC;
      fetch_valid_r <= is_fetching(state_s);
      flush_r       <= (state_s == ST_REDIR);
      stalled_r     <= (state_s == ST_HOLD);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_instr_count (
    .clk   (clk),
    .rst_n (reset),
    .en    (cnt_en_s),
    .count (instr_count)
  );

  assign Current_Address = pc_r;
  assign IA              = ia_r;
  assign fetch_valid     = fetch_valid_r;
  assign flush           = flush_r;
  assign stalled         = stalled_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: a rule-level reference model pushes
// the expected post-edge outputs, a monitor pops and compares them.
// A second instance built with a 4-bit counter exercises saturation.
module tb_pc_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       stall = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_target = 8'h00;

  logic [7:0]  ca, ia, ca4, ia4;
  logic        fv, fl, st, fv4, fl4, st4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .Current_Address(ca), .IA(ia),
    .fetch_valid(fv), .flush(fl), .stalled(st), .instr_count(cnt)
  );

  pc_fetch_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .Current_Address(ca4), .IA(ia4),
    .fetch_valid(fv4), .flush(fl4), .stalled(st4), .instr_count(cnt4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0]  ca;
    logic [7:0]  ia;
    logic        fv;
    logic        fl;
    logic        st;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t q[$];
  int   m_pc;
  bit   m_started, m_bubble, m_stalled;
  int   m_cnt, m_cnt4;

  task automatic reset_model();
    m_pc = 0; m_started = 1'b0; m_bubble = 1'b0; m_stalled = 1'b0;
    m_cnt = 0; m_cnt4 = 0;
  endtask

  exp_t me;
  // Model: apply the sequencing rules to the inputs seen at this edge.
  always @(posedge clk) begin
    if (reset) begin
      m_stalled = 1'b0;
      if (!m_started) begin
        m_started = 1'b1;                 // first edge after reset: start fetching, PC unchanged
      end else if (m_bubble) begin
        m_bubble = 1'b0;                  // bubble lasts exactly one cycle, inputs ignored
      end else if (redirect) begin
        m_pc = int'(redirect_target);
        m_bubble = 1'b1;
      end else if (stall) begin
        m_stalled = 1'b1;
      end else begin
        m_pc = (m_pc + 1) % 256;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      me.ca   = 8'(m_pc);
      me.ia   = 8'((m_pc + 1) % 256);
      me.fv   = !m_bubble;
      me.fl   = m_bubble;
      me.st   = m_stalled;
      me.cnt  = 16'(m_cnt);
      me.cnt4 = 4'(m_cnt4);
      q.push_back(me);
    end
  end

  exp_t ge;
  // Monitor: after each edge, compare the presented outputs with the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (reset && q.size() > 0) begin
      ge = q.pop_front();
      chk("Current_Address", 32'(ca), 32'(ge.ca));
      chk("IA", 32'(ia), 32'(ge.ia));
      chk("fetch_valid", 32'(fv), 32'(ge.fv));
      chk("flush", 32'(fl), 32'(ge.fl));
      chk("stalled", 32'(st), 32'(ge.st));
      chk("instr_count", 32'(cnt), 32'(ge.cnt));
      chk("instr_count_w4", 32'(cnt4), 32'(ge.cnt4));
      chk("Current_Address_w4", 32'(ca4), 32'(ge.ca));
      chk("IA_w4", 32'(ia4), 32'(ge.ia));
      chk("fetch_valid_w4", 32'(fv4), 32'(ge.fv));
      chk("flush_w4", 32'(fl4), 32'(ge.fl));
      chk("stalled_w4", 32'(st4), 32'(ge.st));
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset(input string tag);
    chk({tag, "_ca"}, 32'(ca), 32'h00);
    chk({tag, "_ia"}, 32'(ia), 32'h01);
    chk({tag, "_fv"}, 32'(fv), 32'h0);
    chk({tag, "_flush"}, 32'(fl), 32'h0);
    chk({tag, "_stalled"}, 32'(st), 32'h0);
    chk({tag, "_cnt"}, 32'(cnt), 32'h0);
    chk({tag, "_cnt4"}, 32'(cnt4), 32'h0);
    chk({tag, "_ca4"}, 32'(ca4), 32'h00);
  endtask

  // Run sequentially (no stall/redirect) until the model PC reaches target.
  task automatic goto_pc(input int target);
    int guard;
    guard = 0;
    stall = 1'b0; redirect = 1'b0;
    @(negedge clk);
    while (m_pc != target && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    if (m_pc != target) begin
      n_checks++;
      $display("FAIL goto_pc: timeout, pc %0h required %0h", m_pc, target);
    end
  endtask

  initial begin
    reset_model();
    // Reset state
    reset = 1'b0;
    #12;
    check_reset("reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("cnt_after_4", 32'(cnt), 32'd3);
    chk("ca_after_4", 32'(ca), 32'h03);

    // Stall three cycles at PC=05
    goto_pc(5);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_hold_ca", 32'(ca), 32'h05);
    stall = 1'b0;
    @(negedge clk);
    chk("stall_release_ca", 32'(ca), 32'h06);

    // Redirect with simultaneous stall at PC=10
    goto_pc(16);
    stall = 1'b1; redirect = 1'b1; redirect_target = 8'h40;
    @(negedge clk);
    stall = 1'b0; redirect = 1'b0;
    chk("redir_ca", 32'(ca), 32'h40);
    chk("redir_flush", 32'(fl), 32'h1);
    repeat (2) @(negedge clk);

    // Wrap through FE, FF, 00
    redirect = 1'b1; redirect_target = 8'hFC;
    @(negedge clk);
    redirect = 1'b0;
    goto_pc(0);
    chk("wrap_ia", 32'(ia), 32'h01);

    // Asynchronous reset while in the redirect bubble
    redirect = 1'b1; redirect_target = 8'h77;
    @(posedge clk);
    #3;
    reset = 1'b0; redirect = 1'b0;
    #1;
    check_reset("async_reset");
    q.delete();
    reset_model();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("post_reset_cnt", 32'(cnt), 32'd3);

    // Randomised traffic
    repeat (400) begin
      @(negedge clk);
      stall           = ($urandom_range(0, 3) == 0);
      redirect        = ($urandom_range(0, 9) == 0);
      redirect_target = 8'($urandom_range(0, 255));
    end

    // Saturation of the narrow counter
    stall = 1'b0; redirect = 1'b0;
    repeat (22) @(negedge clk);
    chk("cnt4_saturated", 32'(cnt4), 32'hF);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
